ifetch: RTL and testbench
=========================

# ifetch

Instruction fetch stage sitting directly upstream of the instruction RAM and feeding decode. Holds the program counter, drives the instruction RAM's address and read-enable, absorbs the RAM's one-cycle synchronous read latency, and buffers fetched words in a 2-entry queue. Decode receives them over a valid/ready handshake. Execute can redirect the PC for branches and jumps.

## Interface
- ADDRESS_BUS_WIDTH, 24: PC and RAM address width, taken from the shared params.
- INSTRUCTION_WIDTH, 36: instruction word width, taken from the shared params.
- RESET_PC, 0: PC value loaded at reset.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_address  out  ADDRESS_BUS_WIDTH  address presented to the instruction RAM.
- imem_read_not_write  out  1  tied to 1; fetch never writes.
- imem_data  in  INSTRUCTION_WIDTH  RAM read data, registered by the RAM, one cycle after the address.
- redirect_valid  in  1  one-cycle pulse that loads a new PC.
- redirect_pc  in  ADDRESS_BUS_WIDTH  branch/jump target.
- instr_valid  out  1  queue head is valid.
- instr_ready  in  1  decode accepts the head this cycle.
- instr_out  out  INSTRUCTION_WIDTH  queue head instruction.
- instr_pc  out  ADDRESS_BUS_WIDTH  address of instr_out.

## Operation
- State:
  - pc: next address to issue.
  - pend, pend_pc: one in-flight RAM read.
  - 2-entry queue holding {instr, pc} pairs, with an occupancy count.
- imem_address = pc at all times. The RAM reads every cycle; data is used only when pend=1.
- Issue condition: count + pend − pop < 2, where pop = instr_valid & instr_ready, and no redirect this cycle.
- On issue:
  - pend ← 1, pend_pc ← pc.
  - pc ← pc + 1, wrapping modulo 2^ADDRESS_BUS_WIDTH (word-addressed).
- If no issue: pend ← 0.
- If pend=1 in a cycle: {imem_data, pend_pc} is pushed into the queue at the end of that cycle. The credit rule guarantees the queue never overflows.
- Pop and push in the same cycle are both honoured; count is unchanged.
- Redirect has priority over everything else:
  - Queue is flushed (count ← 0) and pend ← 0; any in-flight data is discarded.
  - pc ← redirect_pc.
  - No issue in the redirect cycle.
  - A valid & ready transfer in the redirect cycle still counts as completed; decode squashes it itself.
- A back-to-back redirect overrides the previous one; the last target wins.
- No address range check. Out-of-range addresses return whatever the RAM returns.
- Reset values:
  - pc = RESET_PC; pend = 0; count = 0.
  - instr_valid = 0; instr_out = 0; instr_pc = 0.
  - imem_address = RESET_PC; imem_read_not_write = 1.

## Timing
- Cycle 0 is the first edge after rst_n deasserts. Issue happens in cycle 0 and the RAM returns data in cycle 1.
- Latency: instr_valid rises in cycle 2 with instr_pc = RESET_PC.
- Issue-to-instr_valid latency is 2 cycles.
- Redirect in cycle c: target issued in c+1, instr_valid with instr_pc = target in c+3.
- Throughput is 1 instruction/cycle when instr_ready is held high.
- Stall: when instr_ready is low, the queue fills to 2 and issue stops. The in-flight read is still captured.
- instr_out and instr_pc are stable while instr_valid=1 and instr_ready=0.
- Reset mid-operation clears the queue and pend immediately (asynchronous). Fetch restarts from RESET_PC as in cycle 0.

## Configuration
- Macro IFETCH_PERF_EN.
- Defined: adds two 16-bit saturating counters, cleared by reset:
  - Output port perf_fetch_count counts completed instr_valid & instr_ready transfers.
  - Output port perf_stall_count counts cycles with instr_valid & !instr_ready.
  - Both hold at 16'hFFFF once saturated.
- Undefined: neither port nor counter exists; the rest of the behaviour is identical.

## Structure
- Shared package/params holds:
  - ADDRESS_BUS_WIDTH, INSTRUCTION_WIDTH.
  - IFETCH_QUEUE_DEPTH = 2.
  - RESET_PC default.
- One sub-module: ifetch_queue, a 2-entry FIFO with push, pop, flush, count and head outputs, storing INSTRUCTION_WIDTH + ADDRESS_BUS_WIDTH bits per entry.
- PC, credit logic and redirect handling stay in ifetch.

## Test plan
- Reset release, instr_ready=1, RAM holding words W0..W5 at addresses 0..5 → instr_valid from cycle 2, consecutive pops W0..W5 with instr_pc 0..5, one per cycle.
- instr_ready=0 for 5 cycles starting in cycle 3 → count saturates at 2, imem_address stops advancing. Head is held stable, and after release the sequence continues with no loss or duplication.
- redirect_valid with redirect_pc=0x20 in cycle 4 → in-flight and queued words dropped, imem_address=0x20 in cycle 5. instr_valid with instr_pc=0x20 in cycle 7, then 0x21.
- Redirect in the same cycle as a pop while the queue is full → pop completes, queue empty next cycle, no stale word appears later.
- redirect_pc = all-ones address → next instr_pc values are 0xFFFFFF, then 0x000000 (wrap).
- With IFETCH_PERF_EN: 10 transfers plus 3 stall cycles → perf_fetch_count=10 and perf_stall_count=3. Forcing 70000 stall cycles → perf_stall_count holds at 0xFFFF.

Source files
------------

// File: rtl/ifetch_pkg.sv
// ifetch_pkg
// Shared parameters and types for the instruction fetch stage.
//   ADDRESS_BUS_WIDTH  : PC / instruction RAM address width (word addressed)
//   INSTRUCTION_WIDTH  : instruction word width
//   IFETCH_QUEUE_DEPTH : entries in the fetch queue feeding decode
//   IFETCH_RESET_PC    : default for the ifetch RESET_PC parameter
package ifetch_pkg;

  localparam int ADDRESS_BUS_WIDTH  = 24;
  localparam int INSTRUCTION_WIDTH  = 36;
  localparam int IFETCH_QUEUE_DEPTH = 2;
  localparam int IFETCH_COUNT_W     = $clog2(IFETCH_QUEUE_DEPTH + 1);
  localparam int IFETCH_PTR_W       = $clog2(IFETCH_QUEUE_DEPTH);

  typedef logic [ADDRESS_BUS_WIDTH-1:0] addr_t;
  typedef logic [INSTRUCTION_WIDTH-1:0] instr_t;
  typedef logic [IFETCH_COUNT_W-1:0]    qcount_t;

  localparam addr_t IFETCH_RESET_PC = '0;

  // One fetched word together with the address it was read from.
  typedef struct packed {
    instr_t instr;
    addr_t  pc;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_if.sv
// ifetch_if
// Bundles the fetch stage's bus signals:
//   imem_address / imem_read_not_write / imem_data : instruction RAM port
//   redirect_valid / redirect_pc                   : PC redirect from execute
//   instr_valid / instr_ready / instr_out / instr_pc : handshake to decode
// master = fetch stage, slave = the RAM/decode/execute environment.
interface ifetch_if;
  import ifetch_pkg::*;

  addr_t  imem_address;
  logic   imem_read_not_write;
  instr_t imem_data;
  logic   redirect_valid;
  addr_t  redirect_pc;
  logic   instr_valid;
  logic   instr_ready;
  instr_t instr_out;
  addr_t  instr_pc;

  modport master (
    output imem_address, imem_read_not_write, instr_valid, instr_out, instr_pc,
    input  imem_data, redirect_valid, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_address, imem_read_not_write, instr_valid, instr_out, instr_pc,
    output imem_data, redirect_valid, redirect_pc, instr_ready
  );

endinterface

// File: rtl/ifetch_queue.sv
// ifetch_queue
// Small circular FIFO of {instr, pc} entries between the RAM and decode.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, push_data : write an entry (ignored when full and not popping)
//   pop        : remove the head (ignored when empty)
//   flush      : empty the queue; takes priority over push and pop
//   count      : current occupancy
//   head       : entry at the head (meaningful only while count != 0)
// Depth must be a power of two so the pointers wrap naturally.
module ifetch_queue
  import ifetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output qcount_t      count,
  output fetch_entry_t head
);

  fetch_entry_t            mem [IFETCH_QUEUE_DEPTH];
  logic [IFETCH_PTR_W-1:0] rd_ptr;
  logic [IFETCH_PTR_W-1:0] wr_ptr;
  logic                    do_push;
  logic                    do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != qcount_t'(IFETCH_QUEUE_DEPTH)) || do_pop);
  assign head    = mem[rd_ptr];

  // Storage is cleared on reset so the head reads as zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < IFETCH_QUEUE_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + qcount_t'(do_push) - qcount_t'(do_pop);
    end
  end

endmodule

// File: rtl/ifetch.sv
// ifetch
// Instruction fetch stage: owns the PC, drives the instruction RAM, absorbs
// its one-cycle read latency and hands words to decode through a 2-entry
// queue.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : ifetch_if.master (RAM port, redirect input, decode handshake)
//   perf_fetch_count, perf_stall_count : 16-bit saturating counters, present
//                only when IFETCH_PERF_EN is defined
// Optional feature macro: IFETCH_PERF_EN.
module ifetch
  import ifetch_pkg::*;
#(
  parameter addr_t RESET_PC = IFETCH_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  ifetch_if.master    bus
`ifdef IFETCH_PERF_EN
  ,
  output logic [15:0] perf_fetch_count,
  output logic [15:0] perf_stall_count
`endif
);

  addr_t        pc;
  addr_t        pend_pc;
  logic         pend;
  logic         pop;
  logic         issue;
  logic [2:0]   credit_used;
  logic [2:0]   credit_limit;
  qcount_t      q_count;
  fetch_entry_t q_head;
  fetch_entry_t q_push_data;

  assign bus.imem_address        = pc;
  assign bus.imem_read_not_write = 1'b1;
  assign bus.instr_valid         = (q_count != '0);
  assign bus.instr_out           = q_head.instr;
  assign bus.instr_pc            = q_head.pc;

  assign pop = bus.instr_valid & bus.instr_ready;

  // A read may only be issued if its word is guaranteed a queue slot when it
  // returns next cycle: queued words plus the one in flight, less the word
  // decode takes this cycle, must leave room.
  assign credit_used  = 3'(q_count) + 3'(pend);
  assign credit_limit = 3'(IFETCH_QUEUE_DEPTH) + 3'(pop);
  assign issue        = !bus.redirect_valid && (credit_used < credit_limit);

  // Redirect overrides any issue and drops the in-flight read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= RESET_PC;
      pend    <= 1'b0;
      pend_pc <= '0;
    end else if (bus.redirect_valid) begin
      pc   <= bus.redirect_pc;
      pend <= 1'b0;
    end else if (issue) begin
      pc      <= pc + addr_t'(1);
      pend    <= 1'b1;
      pend_pc <= pc;
    end else begin
      pend <= 1'b0;
    end
  end

  assign q_push_data = '{instr: bus.imem_data, pc: pend_pc};

  ifetch_queue u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (pend),
    .push_data (q_push_data),
    .pop       (pop),
    .flush     (bus.redirect_valid),
    .count     (q_count),
    .head      (q_head)
  );

`ifdef IFETCH_PERF_EN
  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_count <= '0;
      perf_stall_count <= '0;
    end else begin
      if (pop && (perf_fetch_count != 16'hFFFF)) begin
        perf_fetch_count <= perf_fetch_count + 16'd1;
      end
      if (bus.instr_valid && !bus.instr_ready && (perf_stall_count != 16'hFFFF)) begin
        perf_stall_count <= perf_stall_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch
// Self-checking bench for ifetch. A behavioural RAM returns word_of(addr)
// one cycle after the address. Every redirect or reset release loads a
// queue with the PC sequence decode should see next; each accepted transfer
// is popped from that queue and compared. Perf counter checks are built only
// when IFETCH_PERF_EN is defined.
module tb_ifetch;
  import ifetch_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  ifetch_if bus();

`ifdef IFETCH_PERF_EN
  logic [15:0] perf_fetch_count;
  logic [15:0] perf_stall_count;
`endif

  ifetch dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef IFETCH_PERF_EN
    ,
    .perf_fetch_count (perf_fetch_count),
    .perf_stall_count (perf_stall_count)
`endif
  );

  always #5 clk = ~clk;

  int    testCount  = 0;
  int    failCount  = 0;
  int    cyc        = 0;
  int    xferCount  = 0;
  int    stallTally = 0;
  addr_t sbPc[$];

  // Distinctive RAM contents so a word from the wrong address is caught.
  function automatic instr_t word_of(input addr_t a);
    return {a[11:0] ^ 12'hC3A, a};
  endfunction

  always @(posedge clk) begin
    bus.imem_data <= word_of(bus.imem_address);
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic loadExpected(input addr_t start);
    sbPc.delete();
    for (int i = 0; i < 48; i++) begin
      sbPc.push_back(start + addr_t'(i));
    end
  endtask

  // Drive this cycle's inputs, then at the falling edge score any transfer
  // that the coming rising edge will complete.
  task automatic applyStimulus(input logic ready, input logic redir, input addr_t target);
    bus.instr_ready    = ready;
    bus.redirect_valid = redir;
    bus.redirect_pc    = target;
    @(negedge clk);
    if (bus.instr_valid && ready) begin
      xferCount++;
      if (sbPc.size() == 0) begin
        checkOutput($sformatf("unexpected_xfer@%0d", cyc), 64'(bus.instr_pc), 64'hFFFF_FFFF);
      end else begin
        addr_t e;
        e = sbPc.pop_front();
        checkOutput($sformatf("xfer_pc@%0d", cyc), 64'(bus.instr_pc), 64'(e));
        checkOutput($sformatf("xfer_instr@%0d", cyc), 64'(bus.instr_out), 64'(word_of(e)));
      end
    end
    if (bus.instr_valid && !ready) stallTally++;
    if (redir) loadExpected(target);
  endtask

  task automatic endCycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic doReset();
    rst_n              = 1'b0;
    bus.instr_ready    = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_valid", 64'(bus.instr_valid), 64'd0);
    checkOutput("rst_instr", 64'(bus.instr_out), 64'd0);
    checkOutput("rst_pc", 64'(bus.instr_pc), 64'd0);
    checkOutput("rst_addr", 64'(bus.imem_address), 64'(IFETCH_RESET_PC));
    checkOutput("rst_rnw", 64'(bus.imem_read_not_write), 64'd1);
    rst_n      = 1'b1;
    cyc        = 0;
    xferCount  = 0;
    stallTally = 0;
    loadExpected(IFETCH_RESET_PC);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Streaming with decode always ready.
    doReset();
    for (int c = 0; c < 12; c++) begin
      applyStimulus(1'b1, 1'b0, '0);
      if (c == 0) begin
        checkOutput("A_addr_c0", 64'(bus.imem_address), 64'd0);
        checkOutput("A_valid_c0", 64'(bus.instr_valid), 64'd0);
      end
      if (c == 1) begin
        checkOutput("A_addr_c1", 64'(bus.imem_address), 64'd1);
        checkOutput("A_valid_c1", 64'(bus.instr_valid), 64'd0);
      end
      if (c == 2) begin
        checkOutput("A_valid_c2", 64'(bus.instr_valid), 64'd1);
        checkOutput("A_pc_c2", 64'(bus.instr_pc), 64'd0);
      end
      endCycle();
    end
    checkOutput("A_xfers", 64'(xferCount), 64'd10);

    // Decode stalls for cycles 3..7: queue fills, address freezes.
    doReset();
    for (int c = 0; c < 15; c++) begin
      applyStimulus(!(c >= 3 && c <= 7), 1'b0, '0);
      if (c >= 4 && c <= 7) begin
        checkOutput($sformatf("B_addr_c%0d", c), 64'(bus.imem_address), 64'd3);
        checkOutput($sformatf("B_valid_c%0d", c), 64'(bus.instr_valid), 64'd1);
        checkOutput($sformatf("B_head_pc_c%0d", c), 64'(bus.instr_pc), 64'd1);
        checkOutput($sformatf("B_head_instr_c%0d", c), 64'(bus.instr_out), 64'(word_of(addr_t'(1))));
      end
      endCycle();
    end
    checkOutput("B_xfers", 64'(xferCount), 64'd8);

    // Redirect to 0x20 in cycle 4.
    doReset();
    for (int c = 0; c < 11; c++) begin
      applyStimulus(1'b1, c == 4, addr_t'(24'h20));
      if (c == 5) begin
        checkOutput("C_addr_c5", 64'(bus.imem_address), 64'h20);
        checkOutput("C_valid_c5", 64'(bus.instr_valid), 64'd0);
      end
      if (c == 6) checkOutput("C_valid_c6", 64'(bus.instr_valid), 64'd0);
      if (c == 7) begin
        checkOutput("C_valid_c7", 64'(bus.instr_valid), 64'd1);
        checkOutput("C_pc_c7", 64'(bus.instr_pc), 64'h20);
      end
      if (c == 8) checkOutput("C_pc_c8", 64'(bus.instr_pc), 64'h21);
      endCycle();
    end

    // Redirect together with a pop from a full queue.
    doReset();
    for (int c = 0; c < 13; c++) begin
      applyStimulus(c < 3 || c >= 6, c == 6, addr_t'(24'h40));
      if (c == 6) checkOutput("D_head_pc_c6", 64'(bus.instr_pc), 64'd1);
      if (c == 7 || c == 8) checkOutput($sformatf("D_valid_c%0d", c), 64'(bus.instr_valid), 64'd0);
      if (c == 9) checkOutput("D_pc_c9", 64'(bus.instr_pc), 64'h40);
      endCycle();
    end
    checkOutput("D_xfers", 64'(xferCount), 64'd6);

    // Redirect to the last address: the PC wraps to zero.
    doReset();
    for (int c = 0; c < 10; c++) begin
      applyStimulus(1'b1, c == 3, addr_t'(24'hFFFFFF));
      if (c == 6) checkOutput("E_pc_c6", 64'(bus.instr_pc), 64'hFFFFFF);
      if (c == 7) checkOutput("E_pc_c7", 64'(bus.instr_pc), 64'h0);
      endCycle();
    end

    // Asynchronous reset in the middle of streaming.
    doReset();
    for (int c = 0; c < 5; c++) begin
      applyStimulus(1'b1, 1'b0, '0);
      endCycle();
    end
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("F_async_valid", 64'(bus.instr_valid), 64'd0);
    checkOutput("F_async_addr", 64'(bus.imem_address), 64'(IFETCH_RESET_PC));
    checkOutput("F_async_pc", 64'(bus.instr_pc), 64'd0);
    doReset();
    for (int c = 0; c < 6; c++) begin
      applyStimulus(1'b1, 1'b0, '0);
      if (c == 2) checkOutput("F_pc_c2", 64'(bus.instr_pc), 64'd0);
      endCycle();
    end
    checkOutput("F_xfers", 64'(xferCount), 64'd4);

`ifdef IFETCH_PERF_EN
    // 10 transfers and 3 stalls, then a long stall to saturate.
    doReset();
    for (int c = 0; c < 15; c++) begin
      applyStimulus(!(c >= 3 && c <= 5), 1'b0, '0);
      endCycle();
    end
    bus.instr_ready = 1'b0;
    @(negedge clk);
    checkOutput("P_fetch_count", 64'(perf_fetch_count), 64'd10);
    checkOutput("P_stall_count", 64'(perf_stall_count), 64'd3);
    repeat (70000) @(posedge clk);
    #1;
    checkOutput("P_stall_sat", 64'(perf_stall_count), 64'hFFFF);
    checkOutput("P_fetch_hold", 64'(perf_fetch_count), 64'd10);
`endif

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
